rf_init_fwd: RTL and testbench
==============================

// Module: rf_init_fwd
// PURPOSE
// - Next-generation integer register file for the core: 2 registered read ports, 1 write port fed
//   by a one-hot write-back select (IEU / LSU / incremented PC), parametrised width and depth.
// - Adds async reset, a hardware zero-init sequencer (no software init needed), a depth check
//   for RV32E-style 16-entry files and optional write-to-read forwarding.
// - Sits between decode (read addresses) and write-back; init_busy must stall the front end.
// PARAMETERS
// - XLEN   32  register width in bits
// - NREG   32  architectural registers, 16 or 32; x0 is hard-wired zero, not stored
// PORTS
// - clk         in   1     core clock, all state updates on rising edge
// - reset       in   1     asynchronous, active-high reset
// - rs1_addr    in   5     read port 1 address, sampled when !stall
// - rs2_addr    in   5     read port 2 address, sampled when !stall
// - rd_addr     in   5     write address
// - wb_sel      in   3     one-hot write-back source: [0]=ieu_result [1]=lsu_data [2]=inc_pc
// - ieu_result  in   XLEN  IEU write-back data
// - lsu_data    in   XLEN  LSU write-back data
// - inc_pc      in   XLEN  link address write-back data
// - stall       in   1     hold read outputs
// - rs1_data    out  XLEN  read data 1, registered
// - rs2_data    out  XLEN  read data 2, registered
// - init_busy   out  1     high while zero-init sequencer runs
// - addr_err    out  1     registered pulse: an address >= NREG was used this cycle
// BEHAVIOUR
// - Reset (async assert): rs1_data=rs2_data=0, addr_err=0, init_busy=1, FSM=INIT, init_idx=1.
//   Storage array itself is not reset; it is cleared by INIT.
// - FSM INIT: each cycle writes ram[init_idx]=0, init_idx++. After writing index NREG-1 -> RUN.
//   INIT lasts NREG-1 cycles after reset deassert; init_busy falls on the edge entering RUN.
// - During INIT: external writes dropped, rs*_data held 0, stall ignored, addr_err held 0.
// - Reset asserted mid-INIT or mid-RUN restarts INIT from init_idx=1.
// - Write select priority: inc_pc > lsu_data > ieu_result (highest set bit of wb_sel wins);
//   rd_we = |wb_sel. Write to ram[rd_addr] on clk edge when rd_we, rd_addr!=0, rd_addr<NREG.
// - Writes are independent of stall: a write during stall still commits.
// - Read: 1-cycle latency. When !stall, rsN_data <= (addr==0 || addr>=NREG) ? 0 : ram[addr].
//   When stall, rsN_data holds its value; read addresses are not captured.
// - addr_err <= (!stall && (rs1_addr>=NREG || rs2_addr>=NREG)) || (rd_we && rd_addr>=NREG);
//   single-cycle pulse, never asserted when NREG=32.
// - Out-of-range writes ignored (no aliasing onto low registers). x0 never stores data.
// CONFIGURATION
// - RF_FWD_EN defined: when !stall, rd_we, rd_addr!=0, rd_addr<NREG and rsN_addr==rd_addr,
//   rsN_data <= selected write data (same-cycle write forwarded; new value seen next cycle).
// - RF_FWD_EN undefined: read-before-write; same-cycle read returns the old stored value and
//   the pipeline must insert one bubble for RAW hazards at distance 1.
// - Forwarding never applies to x0, out-of-range addresses or during INIT.
// TESTING
// - Reset, release, count cycles -> init_busy high exactly NREG-1 cycles; then read every
//   register -> all 0x00000000.
// - RUN: wb_sel=3'b001, rd=5, ieu=0xDEADBEEF; next cycle rs1=5 -> rs1_data=0xDEADBEEF one cycle
//   later; rd=0 write of 0x1234 then read x0 -> 0.
// - wb_sel=3'b111, ieu=1, lsu=2, inc_pc=3, rd=7 -> x7 reads 3; wb_sel=3'b011 -> x7 reads 2.
// - stall=1 with rs1 changing, write rd=9=0xA5A5A5A5 -> rs1_data unchanged; stall=0, rs1=9 ->
//   0xA5A5A5A5 (write committed under stall).
// - RF_FWD_EN set: write rd=3=0x55 and rs2=3 same cycle -> rs2_data=0x55 next cycle; unset ->
//   rs2_data=previous x3 value.
// - NREG=16: rs1=20 -> rs1_data=0, addr_err pulses 1 cycle; write rd=20=0xFF -> x4 unchanged;
//   reset mid-INIT -> init_busy stays high, full NREG-1 cycles restart.

Source files
------------

// File: rtl/rf_init_fwd.sv
// rf_init_fwd: 2-read/1-write integer register file with a hardware zero-init sequencer.
// Optional write-to-read forwarding is compiled in when the macro RF_FWD_EN is defined.
module rf_init_fwd #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [2:0]      wb_sel,
  input  logic [XLEN-1:0] ieu_result,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [XLEN-1:0] inc_pc,
  input  logic            stall,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            init_busy,
  output logic            addr_err
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   init_idx_r;
  logic [AW-1:0]   init_idx_nxt_s;
  logic [XLEN-1:0] ram_r [1:NREG-1];

  logic [XLEN-1:0] rs1_data_r;
  logic [XLEN-1:0] rs2_data_r;
  logic            init_busy_r;
  logic            addr_err_r;

  logic [XLEN-1:0] wr_data_s;
  logic            rd_we_s;
  logic            wr_ok_s;
  logic [XLEN-1:0] rs1_nxt_s;
  logic [XLEN-1:0] rs2_nxt_s;
  logic            addr_err_nxt_s;
  logic [AW-1:0]   rs1_idx_s;
  logic [AW-1:0]   rs2_idx_s;
  logic [AW-1:0]   rd_idx_s;

  function automatic logic in_range(input logic [4:0] addr);
    return (int'(addr) < NREG);
  endfunction

  assign rs1_idx_s = rs1_addr[AW-1:0];
  assign rs2_idx_s = rs2_addr[AW-1:0];
  assign rd_idx_s  = rd_addr[AW-1:0];

  // Next-state logic for the init sequencer: sweep indices 1..NREG-1, then run.
  always_comb begin
    state_nxt_s    = state_r;
    init_idx_nxt_s = init_idx_r;
    case (state_r)
      ST_INIT: begin
        init_idx_nxt_s = init_idx_r + AW'(1);
        if (init_idx_r == AW'(NREG - 1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_nxt_s    = ST_RUN;
        init_idx_nxt_s = init_idx_r;
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_idx_nxt_s = AW'(1);
      end
    endcase
  end

  // Write-back select: highest set bit of wb_sel wins; writes only land in RUN.
  always_comb begin
    rd_we_s = |wb_sel;
    if (wb_sel[2]) begin
      wr_data_s = inc_pc;
    end else if (wb_sel[1]) begin
      wr_data_s = lsu_data;
    end else begin
      wr_data_s = ieu_result;
    end
    wr_ok_s = (state_r == ST_RUN) && rd_we_s && (rd_addr != 5'd0) && in_range(rd_addr);
  end

  // Read-port next values; x0 and out-of-range addresses always read as zero.
  always_comb begin
    rs1_nxt_s = '0;
    rs2_nxt_s = '0;
    if ((rs1_addr != 5'd0) && in_range(rs1_addr)) begin
`ifdef RF_FWD_EN
      if (wr_ok_s && (rs1_addr == rd_addr)) begin
        rs1_nxt_s = wr_data_s;
      end else begin
        rs1_nxt_s = ram_r[rs1_idx_s];
      end
`else
      rs1_nxt_s = ram_r[rs1_idx_s];
`endif
    end else begin
      rs1_nxt_s = '0;
    end
    if ((rs2_addr != 5'd0) && in_range(rs2_addr)) begin
`ifdef RF_FWD_EN
      if (wr_ok_s && (rs2_addr == rd_addr)) begin
        rs2_nxt_s = wr_data_s;
      end else begin
        rs2_nxt_s = ram_r[rs2_idx_s];
      end
`else
      rs2_nxt_s = ram_r[rs2_idx_s];
`endif
    end else begin
      rs2_nxt_s = '0;
    end
  end

  // Address error: stalled reads do not count, an unselected write address does not count.
  always_comb begin
    addr_err_nxt_s = 1'b0;
    if (state_r == ST_RUN) begin
      addr_err_nxt_s = (!stall && (!in_range(rs1_addr) || !in_range(rs2_addr))) ||
                       (rd_we_s && !in_range(rd_addr));
    end else begin
      addr_err_nxt_s = 1'b0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_INIT;
      init_idx_r  <= AW'(1);
      init_busy_r <= 1'b1;
      addr_err_r  <= 1'b0;
      rs1_data_r  <= '0;
      rs2_data_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      init_idx_r  <= init_idx_nxt_s;
      init_busy_r <= (state_nxt_s == ST_INIT);
      addr_err_r  <= addr_err_nxt_s;
      if (state_r == ST_INIT) begin
        rs1_data_r <= '0;
        rs2_data_r <= '0;
      end else if (!stall) begin
        rs1_data_r <= rs1_nxt_s;
        rs2_data_r <= rs2_nxt_s;
      end
    end
  end

  // Storage array: cleared by the sequencer, never by reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      ram_r[init_idx_r] <= '0;
    end else if (wr_ok_s) begin
      ram_r[rd_idx_s] <= wr_data_s;
    end
  end

  assign rs1_data  = rs1_data_r;
  assign rs2_data  = rs2_data_r;
  assign init_busy = init_busy_r;
  assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_rf_init_fwd.sv
// Scoreboard bench for rf_init_fwd: a 32-entry and a 16-entry instance share one stimulus
// stream; a queue-based reference model predicts every cycle's outputs for both.
module tb_rf_init_fwd;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  wb_sel;
  logic [31:0] ieu_result, lsu_data, inc_pc;
  logic        stall;

  logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
  logic        busy_a, busy_b, err_a, err_b;

  rf_init_fwd #(.XLEN(32), .NREG(32)) dut32 (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .wb_sel(wb_sel), .ieu_result(ieu_result), .lsu_data(lsu_data), .inc_pc(inc_pc),
    .stall(stall), .rs1_data(rs1_a), .rs2_data(rs2_a), .init_busy(busy_a), .addr_err(err_a)
  );

  rf_init_fwd #(.XLEN(32), .NREG(16)) dut16 (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .wb_sel(wb_sel), .ieu_result(ieu_result), .lsu_data(lsu_data), .inc_pc(inc_pc),
    .stall(stall), .rs1_data(rs1_b), .rs2_data(rs2_b), .init_busy(busy_b), .addr_err(err_b)
  );

  typedef struct packed {
    logic [31:0] rs1_0;
    logic [31:0] rs2_0;
    logic [31:0] rs1_1;
    logic [31:0] rs2_1;
    logic        err_0;
    logic        busy_0;
    logic        err_1;
    logic        busy_1;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance (0: 32 regs, 1: 16 regs)
  int          nreg_m[2] = '{32, 16};
  logic [31:0] mem_m[2][32];
  logic [31:0] rs1_m[2];
  logic [31:0] rs2_m[2];
  logic        err_m[2];
  int          busy_left[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [4:0] a, input bit wok,
                                             input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0 || int'(a) >= nreg_m[k]) return 32'd0;
`ifdef RF_FWD_EN
    if (wok && a == rd) return wd;
`endif
    return mem_m[k][a];
  endfunction

  // Drive one cycle of stimulus and push the predicted post-edge outputs.
  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] ieu,
                      input logic [31:0] lsu, input logic [31:0] pc, input logic stl);
    exp_t e;
    logic [31:0] wd;
    bit we, wok;
    @(negedge clk);
    reset = rst; rs1_addr = a1; rs2_addr = a2; rd_addr = rd; wb_sel = sel;
    ieu_result = ieu; lsu_data = lsu; inc_pc = pc; stall = stl;
    we = (sel != 3'd0);
    wd = sel[2] ? pc : (sel[1] ? lsu : ieu);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy_left[k] = nreg_m[k] - 1;
        rs1_m[k] = 32'd0; rs2_m[k] = 32'd0; err_m[k] = 1'b0;
      end else if (busy_left[k] > 0) begin
        busy_left[k]--;
        rs1_m[k] = 32'd0; rs2_m[k] = 32'd0; err_m[k] = 1'b0;
        if (busy_left[k] == 0) begin
          for (int r = 0; r < 32; r++) mem_m[k][r] = 32'd0;
        end
      end else begin
        wok = we && rd != 5'd0 && int'(rd) < nreg_m[k];
        err_m[k] = (!stl && (int'(a1) >= nreg_m[k] || int'(a2) >= nreg_m[k])) ||
                   (we && int'(rd) >= nreg_m[k]);
        if (!stl) begin
          rs1_m[k] = model_read(k, a1, wok, rd, wd);
          rs2_m[k] = model_read(k, a2, wok, rd, wd);
        end
        if (wok) mem_m[k][rd] = wd;
      end
    end
    e.rs1_0 = rs1_m[0]; e.rs2_0 = rs2_m[0]; e.err_0 = err_m[0]; e.busy_0 = (busy_left[0] > 0);
    e.rs1_1 = rs1_m[1]; e.rs2_1 = rs2_m[1]; e.err_1 = err_m[1]; e.busy_1 = (busy_left[1] > 0);
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, a1, a2, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] ieu,
                    input logic [31:0] lsu, input logic [31:0] pc);
    step(1'b0, 5'd0, 5'd0, rd, sel, ieu, lsu, pc, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare one step after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rs1_data_32",  rs1_a,          e.rs1_0);
        chk("rs2_data_32",  rs2_a,          e.rs2_0);
        chk("addr_err_32",  32'(err_a),     32'(e.err_0));
        chk("init_busy_32", 32'(busy_a),    32'(e.busy_0));
        chk("rs1_data_16",  rs1_b,          e.rs1_1);
        chk("rs2_data_16",  rs2_b,          e.rs2_1);
        chk("addr_err_16",  32'(err_b),     32'(e.err_1));
        chk("init_busy_16", 32'(busy_b),    32'(e.busy_1));
      end
    end
  end

  initial begin
    reset = 1'b1; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; wb_sel = '0;
    ieu_result = '0; lsu_data = '0; inc_pc = '0; stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = nreg_m[k] - 1; rs1_m[k] = '0; rs2_m[k] = '0; err_m[k] = 1'b0;
      for (int r = 0; r < 32; r++) mem_m[k][r] = '0;
    end

    repeat (3) step(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0);
    // Partial init with writes, stalls and bad addresses that must all be ignored
    repeat (6) step(1'b0, 5'd20, 5'd3, 5'd4, 3'b001, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (34) idle(5'd0, 5'd0);

    // Every register reads zero after init
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    wr(5'd5, 3'b001, 32'hDEAD_BEEF, 32'd0, 32'd0);
    idle(5'd5, 5'd0);
    wr(5'd0, 3'b001, 32'h0000_1234, 32'd0, 32'd0);
    idle(5'd0, 5'd5);
    wr(5'd7, 3'b111, 32'd1, 32'd2, 32'd3);
    idle(5'd7, 5'd0);
    wr(5'd7, 3'b011, 32'd1, 32'd2, 32'd3);
    idle(5'd7, 5'd7);

    // Write under stall still commits; read outputs hold
    idle(5'd5, 5'd7);
    step(1'b0, 5'd7, 5'd1, 5'd9, 3'b001, 32'hA5A5_A5A5, 32'd0, 32'd0, 1'b1);
    step(1'b0, 5'd9, 5'd20, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b1);
    idle(5'd9, 5'd0);

    // Same-cycle write/read of x3
    wr(5'd3, 3'b001, 32'h0000_0011, 32'd0, 32'd0);
    step(1'b0, 5'd0, 5'd3, 5'd3, 3'b001, 32'h0000_0055, 32'd0, 32'd0, 1'b0);
    idle(5'd3, 5'd3);

    // Out-of-range access on the 16-entry file
    idle(5'd20, 5'd0);
    idle(5'd0, 5'd0);
    wr(5'd20, 3'b001, 32'h0000_00FF, 32'd0, 32'd0);
    idle(5'd4, 5'd20);
    step(1'b0, 5'd0, 5'd0, 5'd31, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      step(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0));
    end

    // Mid-RUN reset restarts the full init
    step(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (33) idle(5'd5, 5'd7);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
